// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues one memory read per instruction, holds the
// returned word until the downstream stage retires it, and traps on timeout or misaligned PC.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          TIMEOUT  = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] next_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic        fetch_err,
    output logic [1:0]  err_cause,
    output logic [31:0] retired
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2,
        ERROR = 2'd3
    } state_t;

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t     state;
    logic [7:0] wait_cnt;

    // The request is gated by rst so it never shows while reset is held,
    // yet appears in the very first cycle after rst drops.
    assign imem_req  = (state == FETCH) && !rst;
    assign imem_addr = pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= FETCH;
            pc          <= RESET_PC;
            instr       <= 32'h0;
            instr_valid <= 1'b0;
            fetch_err   <= 1'b0;
            err_cause   <= 2'b00;
            retired     <= 32'h0;
            wait_cnt    <= 8'h0;
        end else begin
            case (state)
                FETCH: begin
                    wait_cnt <= 8'h0;
                    state    <= WAIT;
                end
                WAIT: begin
                    // A response in the last allowed cycle wins over the timeout.
                    if (imem_rvalid) begin
                        instr       <= imem_rdata;
                        instr_valid <= 1'b1;
                        state       <= HOLD;
                    end else begin
                        wait_cnt <= wait_cnt + 8'h1;
                        if (wait_cnt == WAIT_LAST) begin
                            state     <= ERROR;
                            fetch_err <= 1'b1;
                            err_cause <= 2'b01;
                        end
                    end
                end
                HOLD: begin
                    if (instr_ready) begin
                        pc          <= next_pc;
                        retired     <= retired + 32'h1;
                        instr_valid <= 1'b0;
                        // A misaligned target is still retired and kept in pc for debug.
                        if (next_pc[1:0] != 2'b00) begin
                            state     <= ERROR;
                            fetch_err <= 1'b1;
                            err_cause <= 2'b10;
                        end else begin
                            state <= FETCH;
                        end
                    end
                end
                ERROR: state <= ERROR;
                default: state <= FETCH;
            endcase
        end
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  RESET_PC    32'h0000_0000   PC value loaded on reset
  TIMEOUT     15              max WAIT cycles before fetch error (1..255)
REQ-002 Clocking SHALL be one clock, clk; reset rst is synchronous and active-high.
REQ-003 Ports SHALL be, one per line: name, direction, width, meaning.
  clk          in   1   clock, rising edge
  rst          in   1   synchronous active-high reset
  next_pc      in   32  next PC from the PC-update stage, sampled on retire
  imem_req     out  1   single-cycle read request to instruction memory
  imem_addr    out  32  read address, equals pc
  imem_rvalid  in   1   read data valid
  imem_rdata   in   32  read data
  pc           out  32  address of the currently held instruction (PC-update "old")
  instr        out  32  held instruction word
  instr_valid  out  1   instr/pc valid for downstream
  instr_ready  in   1   downstream accepts instr this cycle (retire)
  fetch_err    out  1   sticky error flag
  err_cause    out  2   00 none, 01 timeout, 10 misaligned next_pc
  retired      out  32  count of retired instructions

Function
REQ-004 The FSM SHALL have states FETCH, WAIT, HOLD and ERROR, and enter FETCH on reset.
REQ-005 In FETCH the block SHALL assert imem_req for exactly one cycle with imem_addr=pc, then enter WAIT.
REQ-006 In WAIT the block SHALL increment an 8-bit wait counter (cleared on entry) every cycle without imem_rvalid.
REQ-007 In WAIT, imem_rvalid=1 SHALL latch imem_rdata into instr, set instr_valid=1 on the next cycle and enter HOLD.
- Minimum fetch latency: 2 cycles from FETCH entry to instr_valid.
REQ-008 In WAIT, if the counter reaches TIMEOUT with imem_rvalid=0, the block SHALL enter ERROR with err_cause=01.
- imem_rvalid in that same cycle SHALL take priority over the timeout.
REQ-009 imem_rvalid SHALL be ignored in FETCH, HOLD and ERROR.
REQ-010 In HOLD, instr and pc SHALL stay stable with instr_valid=1 until instr_ready=1.
REQ-011 On instr_valid & instr_ready the block SHALL perform all of the following:
- pc <= next_pc
- retired <= retired+1, wrapping from 32'hFFFF_FFFF to 0
- instr_valid <= 0
- enter FETCH
REQ-012 If next_pc[1:0]!=2'b00 at retire, the block SHALL:
- still count the retire
- enter ERROR with err_cause=10
- load pc with the offending next_pc for debug
REQ-013 instr_ready SHALL have no effect while instr_valid=0.
REQ-014 ERROR SHALL be sticky until rst, with the following outputs held:
- fetch_err=1
- imem_req=0
- instr_valid=0
- pc, instr and retired frozen
REQ-015 imem_addr SHALL equal pc in every state; imem_req SHALL be 1 only in FETCH.
REQ-016 pc SHALL change only at reset or at retire.

Reset
REQ-017 rst=1 on a clock edge SHALL set the following, overriding every other input that cycle, including mid-WAIT or mid-HOLD:
- state FETCH
- pc=RESET_PC
- instr=0
- instr_valid=0
- imem_req=0
- fetch_err=0
- err_cause=00
- retired=0
- wait counter=0
REQ-018 The first imem_req SHALL assert in the first cycle after rst deasserts, with imem_addr=RESET_PC.
REQ-019 A response arriving after reset from a request issued before reset SHALL be ignored unless the block is in WAIT.

Verification
REQ-020 Basic fetch: rst, then rvalid one cycle after req with rdata=32'h2002_0005, instr_ready=1 held, next_pc=4 -> instr_valid 2 cycles after req, pc=0 then 4, retired=1, second req at addr 4.
REQ-021 Backpressure: instr_ready=0 for 5 cycles during HOLD -> instr, pc and instr_valid stable, no imem_req; ready=1 -> single retire, retired increments by exactly 1.
REQ-022 Timeout: no rvalid with TIMEOUT=15 -> fetch_err=1, err_cause=01 after 15 WAIT cycles, imem_req stays 0; rvalid arriving on cycle 15 instead -> normal HOLD, no error.
REQ-023 Misaligned: retire with next_pc=32'h0000_0046 -> ERROR, err_cause=10, pc=32'h0000_0046, retired incremented, no further imem_req.
REQ-024 Reset mid-operation: rst pulsed in WAIT, then a stale rvalid -> that rvalid ignored, new req to RESET_PC, retired=0, fetch_err=0.
REQ-025 Wrap: preload retired to 32'hFFFF_FFFF via forced state, one retire -> retired=0.
